// File: rtl/param_data_cache_if.sv
// Request/response and next-level memory bus for param_data_cache.
// master = requester and memory model side, slave = the cache.
interface param_data_cache_if #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6
);
    logic                       req_valid;
    logic                       req_ready;
    logic [3:0]                 req_cmd;
    logic [ADDR_W-1:0]          req_addr;
    logic                       resp_valid;
    logic                       resp_hit;
    logic                       mem_valid;
    logic                       mem_ready;
    logic [1:0]                 mem_cmd;
    logic [ADDR_W-OFFSET_W-1:0] mem_addr;

    modport master (
        output req_valid, req_cmd, req_addr, mem_ready,
        input  req_ready, resp_valid, resp_hit, mem_valid, mem_cmd, mem_addr
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, mem_ready,
        output req_ready, resp_valid, resp_hit, mem_valid, mem_cmd, mem_addr
    );
endinterface

// File: rtl/param_data_cache.sv
// Set-associative write-back cache tag/state controller with true-LRU ages,
// dirty write-back, invalidate/clear commands and saturating statistics.
module param_data_cache #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int SET_W    = 14,
    parameter int WAYS     = 4,
    parameter int STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    param_data_cache_if.slave bus,
    output logic [STAT_W-1:0] stat_hit,
    output logic [STAT_W-1:0] stat_miss,
    output logic [STAT_W-1:0] stat_reads,
    output logic [STAT_W-1:0] stat_writes
);
    localparam int TAG_W  = ADDR_W - SET_W - OFFSET_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int LINE_W = ADDR_W - OFFSET_W;
    localparam int SETS   = 1 << SET_W;

    localparam logic [3:0] CMD_READ  = 4'd0;
    localparam logic [3:0] CMD_WRITE = 4'd1;
    localparam logic [3:0] CMD_INVAL = 4'd3;
    localparam logic [3:0] CMD_CLEAR = 4'd8;
    localparam logic [1:0] MEM_RD    = 2'b01;
    localparam logic [1:0] MEM_WB    = 2'b10;
    localparam logic [1:0] MEM_RWITM = 2'b11;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_WB, S_FILL, S_RESP} state_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    state_t              state_q, state_d;
    logic [SET_W-1:0]    sweep_q, sweep_d;
    logic [3:0]          cmd_q;
    logic [LINE_W-1:0]   line_q;
    logic [WAY_W-1:0]    way_q, way_d;
    logic                hit_q, hit_d;
    logic                resp_valid_q, resp_hit_q;
    logic [STAT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [STAT_W-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    // Per-set state arrays, one write and one registered read per cycle
    logic [WAYS-1:0]       valid_mem [SETS];
    logic [WAYS-1:0]       dirty_mem [SETS];
    logic [WAYS*TAG_W-1:0] tag_mem   [SETS];
    logic [WAYS*WAY_W-1:0] age_mem   [SETS];

    logic [WAYS-1:0]       rd_valid_q, rd_dirty_q;
    logic [WAYS*TAG_W-1:0] rd_tag_q;
    logic [WAYS*WAY_W-1:0] rd_age_q;

    logic                  rd_en, wr_en, accept;
    logic [SET_W-1:0]      rd_set, wr_set;
    logic [WAYS-1:0]       wr_valid, wr_dirty;
    logic [WAYS*TAG_W-1:0] wr_tag;
    logic [WAYS*WAY_W-1:0] wr_age, init_age, new_age;

    logic [SET_W-1:0]      req_set;
    logic [TAG_W-1:0]      req_tag;
    logic [TAG_W-1:0]      rd_tag_w [WAYS];
    logic [WAY_W-1:0]      age_w    [WAYS];
    logic [WAYS-1:0]       hit_vec;
    logic                  any_hit;
    logic [WAY_W-1:0]      hit_way, victim, acc_way, acc_old;

    logic                  req_ready_c, mem_valid_c;
    logic [1:0]            mem_cmd_c;
    logic [LINE_W-1:0]     mem_addr_c;

    assign req_set = line_q[SET_W-1:0];
    assign req_tag = line_q[LINE_W-1:SET_W];
    assign rd_set  = bus.req_addr[OFFSET_W +: SET_W];
    assign accept  = (state_q == S_IDLE) && bus.req_valid;
    assign rd_en   = accept;
    assign any_hit = |hit_vec;
    assign acc_way = (state_q == S_FILL) ? way_q : hit_way;
    assign acc_old = age_w[acc_way];

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign rd_tag_w[gi] = rd_tag_q[gi*TAG_W +: TAG_W];
            assign age_w[gi]    = rd_age_q[gi*WAY_W +: WAY_W];
            assign hit_vec[gi]  = rd_valid_q[gi] && (rd_tag_w[gi] == req_tag);
            assign init_age[gi*WAY_W +: WAY_W] = WAY_W'(gi);
            // Accessed way becomes youngest; only ways younger than it age by one
            assign new_age[gi*WAY_W +: WAY_W] =
                (WAY_W'(gi) == acc_way) ? '0 :
                (age_w[gi] < acc_old)   ? age_w[gi] + WAY_W'(1) : age_w[gi];
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        victim  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = WAY_W'(i);
            if (age_w[i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
        end
        // An empty way always beats the LRU way; lowest index wins
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!rd_valid_q[i]) victim = WAY_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        way_d       = way_q;
        hit_d       = hit_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        wr_en       = 1'b0;
        wr_set      = req_set;
        wr_valid    = rd_valid_q;
        wr_dirty    = rd_dirty_q;
        wr_tag      = rd_tag_q;
        wr_age      = rd_age_q;
        req_ready_c = 1'b0;
        mem_valid_c = 1'b0;
        mem_cmd_c   = 2'b00;
        mem_addr_c  = '0;
        case (state_q)
            S_INIT: begin
                wr_en    = 1'b1;
                wr_set   = sweep_q;
                wr_valid = '0;
                wr_dirty = '0;
                wr_age   = init_age;
                sweep_d  = sweep_q + SET_W'(1);
                if (sweep_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                case (cmd_q)
                    CMD_READ, CMD_WRITE: begin
                        if (cmd_q == CMD_WRITE) wr_cnt_d = sat_inc(wr_cnt_q);
                        else                    rd_cnt_d = sat_inc(rd_cnt_q);
                        hit_d = any_hit;
                        if (any_hit) begin
                            hit_cnt_d = sat_inc(hit_cnt_q);
                            wr_en     = 1'b1;
                            wr_age    = new_age;
                            if (cmd_q == CMD_WRITE) wr_dirty[hit_way] = 1'b1;
                            state_d   = S_RESP;
                        end else begin
                            miss_cnt_d = sat_inc(miss_cnt_q);
                            way_d      = victim;
                            state_d    = (rd_valid_q[victim] && rd_dirty_q[victim]) ? S_WB : S_FILL;
                        end
                    end
                    CMD_INVAL: begin
                        hit_d = any_hit;
                        way_d = hit_way;
                        if (any_hit && rd_dirty_q[hit_way]) begin
                            state_d = S_WB;
                        end else begin
                            if (any_hit) begin
                                wr_en             = 1'b1;
                                wr_valid[hit_way] = 1'b0;
                                wr_dirty[hit_way] = 1'b0;
                            end
                            state_d = S_RESP;
                        end
                    end
                    CMD_CLEAR: begin
                        hit_cnt_d  = '0;
                        miss_cnt_d = '0;
                        rd_cnt_d   = '0;
                        wr_cnt_d   = '0;
                        sweep_d    = '0;
                        state_d    = S_INIT;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_WB: begin
                mem_valid_c = 1'b1;
                mem_cmd_c   = MEM_WB;
                mem_addr_c  = {rd_tag_w[way_q], req_set};
                if (bus.mem_ready) begin
                    if (cmd_q == CMD_INVAL) begin
                        wr_en           = 1'b1;
                        wr_valid[way_q] = 1'b0;
                        wr_dirty[way_q] = 1'b0;
                        state_d         = S_RESP;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                mem_valid_c = 1'b1;
                mem_cmd_c   = (cmd_q == CMD_WRITE) ? MEM_RWITM : MEM_RD;
                mem_addr_c  = line_q;
                if (bus.mem_ready) begin
                    wr_en                         = 1'b1;
                    wr_valid[way_q]               = 1'b1;
                    wr_dirty[way_q]               = (cmd_q == CMD_WRITE);
                    wr_tag[way_q*TAG_W +: TAG_W]  = req_tag;
                    wr_age                        = new_age;
                    state_d                       = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_set] <= wr_valid;
            dirty_mem[wr_set] <= wr_dirty;
            tag_mem[wr_set]   <= wr_tag;
            age_mem[wr_set]   <= wr_age;
        end
        if (rd_en) begin
            rd_valid_q <= valid_mem[rd_set];
            rd_dirty_q <= dirty_mem[rd_set];
            rd_tag_q   <= tag_mem[rd_set];
            rd_age_q   <= age_mem[rd_set];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            cmd_q        <= '0;
            line_q       <= '0;
            way_q        <= '0;
            hit_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            way_q        <= way_d;
            hit_q        <= hit_d;
            resp_valid_q <= (state_q == S_RESP);
            resp_hit_q   <= (state_q == S_RESP) && hit_q;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            if (accept) begin
                cmd_q  <= bus.req_cmd;
                line_q <= bus.req_addr[ADDR_W-1:OFFSET_W];
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.mem_valid  = mem_valid_c;
    assign bus.mem_cmd    = mem_cmd_c;
    assign bus.mem_addr   = mem_addr_c;
    assign stat_hit       = hit_cnt_q;
    assign stat_miss      = miss_cnt_q;
    assign stat_reads     = rd_cnt_q;
    assign stat_writes    = wr_cnt_q;
endmodule

// File: tb/tb_param_data_cache.sv
// Directed bench for param_data_cache: 4 sets, 2 ways, 2-bit statistics so
// saturation is reachable; every expectation below is hand-derived.
module tb_param_data_cache;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int SET_W    = 2;
    localparam int WAYS     = 2;
    localparam int STAT_W   = 2;
    localparam int LINE_W   = ADDR_W - OFFSET_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_data_cache_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) bus ();
    logic [STAT_W-1:0] stat_hit, stat_miss, stat_reads, stat_writes;

    param_data_cache #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SET_W(SET_W), .WAYS(WAYS), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_hit(stat_hit), .stat_miss(stat_miss),
        .stat_reads(stat_reads), .stat_writes(stat_writes)
    );

    int n_checks = 0;
    int n_errors = 0;

    int              n_mem;
    logic [1:0]      mcmd  [4];
    logic [LINE_W-1:0] maddr [4];
    logic            got_resp, got_hit;
    int              lat;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int h, input int m, input int r, input int w);
        check_val({tag, "_hit"},    stat_hit,    h);
        check_val({tag, "_miss"},   stat_miss,   m);
        check_val({tag, "_reads"},  stat_reads,  r);
        check_val({tag, "_writes"}, stat_writes, w);
    endtask

    task automatic do_reset(input string tag);
        int n;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        check_val({tag, "_rst_req_ready"},  bus.req_ready,  0);
        check_val({tag, "_rst_resp_valid"}, bus.resp_valid, 0);
        check_val({tag, "_rst_resp_hit"},   bus.resp_hit,   0);
        check_val({tag, "_rst_mem_valid"},  bus.mem_valid,  0);
        check_val({tag, "_rst_mem_cmd"},    bus.mem_cmd,    0);
        check_val({tag, "_rst_mem_addr"},   bus.mem_addr,   0);
        check_stats({tag, "_rst"}, 0, 0, 0, 0);
        rst = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_init_cycles"}, n, 4);
        $display("reset %s: req_ready after %0d cycles", tag, n);
    endtask

    task automatic accept_req(input logic [3:0] cmd, input logic [31:0] addr);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("accept_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_addr  = addr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // stall > 0 holds mem_ready low for stall-1 edges of the first memory state
    task automatic run_req(input logic [3:0] cmd, input logic [31:0] addr, input int stall,
                           input logic [1:0] s_cmd, input logic [LINE_W-1:0] s_addr);
        int stall_left;
        n_mem      = 0;
        got_resp   = 1'b0;
        got_hit    = 1'b0;
        lat        = 0;
        stall_left = stall;
        bus.mem_ready = (stall == 0);
        accept_req(cmd, addr);
        while (!got_resp && lat < 100) begin
            if (bus.mem_valid && stall_left > 0) begin
                check_val("bp_mem_cmd",  bus.mem_cmd,    s_cmd);
                check_val("bp_mem_addr", bus.mem_addr,   s_addr);
                check_val("bp_no_resp",  bus.resp_valid, 0);
                stall_left--;
                if (stall_left == 0) bus.mem_ready = 1'b1;
            end
            if (bus.mem_valid && bus.mem_ready) begin
                if (n_mem < 4) begin
                    mcmd[n_mem]  = bus.mem_cmd;
                    maddr[n_mem] = bus.mem_addr;
                end
                n_mem++;
            end
            @(posedge clk); #1;
            lat++;
            if (bus.resp_valid) begin
                got_resp = 1'b1;
                got_hit  = bus.resp_hit;
            end
        end
        bus.mem_ready = 1'b1;
        $display("req cmd=%0d addr=0x%08h -> resp=%0d hit=%0d lat=%0d mem_xfers=%0d",
                 cmd, addr, got_resp, got_hit, lat, n_mem);
    endtask

    task automatic issue_noresp(input logic [3:0] cmd, input logic [31:0] addr, output int n, output logic saw);
        accept_req(cmd, addr);
        n   = 0;
        saw = 1'b0;
        while (!bus.req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (bus.resp_valid) saw = 1'b1;
        end
        $display("req cmd=%0d addr=0x%08h -> no-resp cmd, ready after %0d cycles, resp_seen=%0d",
                 cmd, addr, n, saw);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic saw;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = 4'd0;
        bus.req_addr  = 32'd0;
        bus.mem_ready = 1'b1;

        do_reset("por");

        // Read miss then hit on set 0, tag 0x10
        run_req(4'd0, 32'h0000_1000, 0, 2'd0, '0);
        check_val("rm_resp",  got_resp, 1);
        check_val("rm_hit",   got_hit,  0);
        check_val("rm_lat",   lat,      3);
        check_val("rm_nmem",  n_mem,    1);
        check_val("rm_cmd",   mcmd[0],  2'b01);
        check_val("rm_addr",  maddr[0], 26'h40);
        run_req(4'd0, 32'h0000_1000, 0, 2'd0, '0);
        check_val("rh_resp",  got_resp, 1);
        check_val("rh_hit",   got_hit,  1);
        check_val("rh_lat",   lat,      2);
        check_val("rh_nmem",  n_mem,    0);
        check_stats("rmh", 1, 1, 2, 0);

        // Dirty eviction in set 0 and LRU ordering
        do_reset("evict");
        run_req(4'd1, 32'h0000_0000, 0, 2'd0, '0);
        check_val("w0_hit",  got_hit,  0);
        check_val("w0_cmd",  mcmd[0],  2'b11);
        check_val("w0_addr", maddr[0], 26'h0);
        run_req(4'd1, 32'h0000_0100, 0, 2'd0, '0);
        check_val("w1_cmd",  mcmd[0],  2'b11);
        check_val("w1_addr", maddr[0], 26'h4);
        run_req(4'd0, 32'h0000_0200, 0, 2'd0, '0);
        check_val("ev_resp", got_resp, 1);
        check_val("ev_hit",  got_hit,  0);
        check_val("ev_nmem", n_mem,    2);
        check_val("ev_lat",  lat,      4);
        check_val("ev_wb_cmd",   mcmd[0],  2'b10);
        check_val("ev_wb_addr",  maddr[0], 26'h0);
        check_val("ev_fl_cmd",   mcmd[1],  2'b01);
        check_val("ev_fl_addr",  maddr[1], 26'h8);
        run_req(4'd0, 32'h0000_0100, 0, 2'd0, '0);
        check_val("lru_keep_hit", got_hit, 1);
        run_req(4'd0, 32'h0000_0000, 0, 2'd0, '0);
        check_val("lru_vict_hit",  got_hit,  0);
        check_val("lru_vict_nmem", n_mem,    1);
        check_val("lru_vict_cmd",  mcmd[0],  2'b01);
        check_stats("evict", 1, 3, 3, 2);

        // Memory backpressure during FILL
        do_reset("bp");
        run_req(4'd0, 32'h0000_1000, 6, 2'b01, 26'h40);
        check_val("bp_resp", got_resp, 1);
        check_val("bp_lat",  lat,      8);
        check_val("bp_nmem", n_mem,    1);
        check_val("bp_addr", maddr[0], 26'h40);

        // Invalidate: dirty hit writes back, clean hit does not, miss reports no hit
        do_reset("inval");
        run_req(4'd1, 32'h0000_0040, 0, 2'd0, '0);
        check_val("iw_addr", maddr[0], 26'h1);
        run_req(4'd3, 32'h0000_0040, 0, 2'd0, '0);
        check_val("inv_d_resp", got_resp, 1);
        check_val("inv_d_hit",  got_hit,  1);
        check_val("inv_d_nmem", n_mem,    1);
        check_val("inv_d_cmd",  mcmd[0],  2'b10);
        check_val("inv_d_addr", maddr[0], 26'h1);
        run_req(4'd0, 32'h0000_0040, 0, 2'd0, '0);
        check_val("inv_rd_hit",  got_hit, 0);
        check_val("inv_rd_nmem", n_mem,   1);
        run_req(4'd3, 32'h0000_0040, 0, 2'd0, '0);
        check_val("inv_c_hit",  got_hit, 1);
        check_val("inv_c_nmem", n_mem,   0);
        run_req(4'd3, 32'h0000_0040, 0, 2'd0, '0);
        check_val("inv_m_resp", got_resp, 1);
        check_val("inv_m_hit",  got_hit,  0);
        check_stats("inval", 0, 2, 1, 1);

        // Unsupported command and clear
        issue_noresp(4'd5, 32'h0000_0040, n, saw);
        check_val("ign_cycles", n,   1);
        check_val("ign_resp",   saw, 0);
        run_req(4'd0, 32'h0000_0040, 0, 2'd0, '0);
        check_val("pre_clr_hit", got_hit, 0);
        check_stats("pre_clr", 0, 3, 2, 1);
        issue_noresp(4'd8, 32'h0, n, saw);
        check_val("clr_cycles", n,   5);
        check_val("clr_resp",   saw, 0);
        check_stats("clr", 0, 0, 0, 0);
        run_req(4'd0, 32'h0000_0040, 0, 2'd0, '0);
        check_val("post_clr_hit", got_hit, 0);

        // Counter saturation at 2 bits
        do_reset("sat");
        for (int i = 0; i < 4; i++) run_req(4'd0, 32'h0000_0000, 0, 2'd0, '0);
        check_stats("sat", 3, 1, 3, 0);
        @(posedge clk); #1;
        check_val("resp_pulse_end", bus.resp_valid, 0);

        // Reset in the middle of a FILL abandons it
        bus.mem_ready = 1'b0;
        accept_req(4'd0, 32'h0000_1000);
        @(posedge clk); #1;
        check_val("mid_fill_valid", bus.mem_valid, 1);
        rst = 1'b1;
        #1;
        check_val("mid_rst_mem_valid", bus.mem_valid, 0);
        check_val("mid_rst_mem_cmd",   bus.mem_cmd,   0);
        do_reset("mid");
        run_req(4'd0, 32'h0000_1000, 0, 2'd0, '0);
        check_val("mid_after_hit",  got_hit, 0);
        check_val("mid_after_nmem", n_mem,   1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/param_data_cache.md
PARAM_DATA_CACHE -- requirements
Module: param_data_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-002 SHALL have parameter OFFSET_W, default 6, meaning line offset bits (64 B line).
REQ-003 SHALL have parameter SET_W, default 14, meaning index bits (2^SET_W sets).
REQ-004 SHALL have parameter WAYS, default 4, meaning associativity, power of 2, 2..8.
REQ-005 SHALL have parameter STAT_W, default 32, meaning statistics counter width.
REQ-006 SHALL derive TAG_W = ADDR_W-SET_W-OFFSET_W and WAY_W = log2(WAYS).
REQ-007 SHALL have port clk, input, 1 bit: the one clock; all state on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port req_valid, input, 1 bit: request present.
REQ-010 SHALL have port req_ready, output, 1 bit: request accepted when both high.
REQ-011 SHALL have port req_cmd, input, 4 bits: 0 read, 1 write, 3 invalidate, 8 clear; others ignored.
REQ-012 SHALL have port req_addr, input, ADDR_W bits: tag, then set, then offset, MSB first.
REQ-013 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port resp_hit, output, 1 bit: lookup hit, qualified by resp_valid.
REQ-015 SHALL have port mem_valid, output, 1 bit: next-level request.
REQ-016 SHALL have port mem_ready, input, 1 bit: next-level accept.
REQ-017 SHALL have port mem_cmd, output, 2 bits: 01 read, 10 write-back, 11 read-with-intent-to-modify.
REQ-018 SHALL have port mem_addr, output, ADDR_W-OFFSET_W bits: line address.
REQ-019 SHALL have ports stat_hit, stat_miss, stat_reads, stat_writes, output, STAT_W bits each.

Function
REQ-020 SHALL hold per line: valid, dirty, tag; per set: WAYS age fields of WAY_W bits.
REQ-021 SHALL implement FSM states INIT, IDLE, LOOKUP, WB, FILL, RESP.
REQ-022 SHALL in INIT clear valid/dirty and set age[w]=w for one set per cycle, indices 0..2^SET_W-1, then go to IDLE; req_ready low throughout.
REQ-023 SHALL drive req_ready high only in IDLE; handshake latches req_cmd and req_addr, then goes to LOOKUP (ignored cmds return to IDLE, no resp).
REQ-024 SHALL on clear (8) zero all stats and enter INIT; no resp_valid.
REQ-025 SHALL in LOOKUP count read/write into stat_reads/stat_writes and hit/miss; invalidate changes no stats; all counters saturate at all-ones.
REQ-026 SHALL on read/write hit update LRU, set dirty on write, go to RESP; resp_valid exactly 2 cycles after accept edge.
REQ-027 SHALL choose victim on miss: lowest-index invalid way, else way with age WAYS-1.
REQ-028 SHALL on miss with valid dirty victim enter WB: mem_cmd 10, mem_addr {victim tag, set}; else go directly to FILL.
REQ-029 SHALL in FILL issue mem_cmd 01 (read) or 11 (write), mem_addr = req line; on handshake install tag, valid=1, dirty=(write), update LRU, go to RESP.
REQ-030 SHALL keep mem_valid/mem_cmd/mem_addr stable until mem_ready; exactly one transfer per handshake cycle; mem_addr=0, mem_cmd=00 when mem_valid low.
REQ-031 SHALL update LRU: accessed way age to 0; ways with age below accessed way's old age increment; others unchanged; ages stay a permutation.
REQ-032 SHALL on invalidate hit to dirty line do WB first, then clear valid/dirty; clean hit clears immediately; resp_hit = tag match; LRU unchanged.
REQ-033 SHALL in RESP pulse resp_valid one cycle, then IDLE.
REQ-034 SHALL treat mem_ready high in the cycle mem_valid rises as immediate accept (one cycle per memory state).

Reset
REQ-035 SHALL on rst asynchronously force: state INIT, sweep index 0, req_ready 0, resp_valid 0, resp_hit 0, mem_valid 0, mem_cmd 00, mem_addr 0, all stats 0.
REQ-036 SHALL on rst mid-operation abandon any WB/FILL without completing; sweep restarts from set 0 after rst falls.

Verification (SET_W=2, WAYS=2, OFFSET_W=6, ADDR_W=32, mem_ready tied 1 unless stated)
REQ-037 SHALL cover reset: rst pulse -> req_ready low 4 cycles, then high; all stats 0.
REQ-038 SHALL cover read miss then hit: read 0x00001000 twice -> one mem_cmd 01 addr 0x000040; second resp_hit=1; stat_hit=1, stat_miss=1, stat_reads=2.
REQ-039 SHALL cover dirty eviction: write 0x000, write 0x100, read 0x200 (set 0) -> WB mem_cmd 10 addr 0x000000, then FILL 01 addr 0x000008.
REQ-040 SHALL cover backpressure: mem_ready low 5 cycles during FILL -> mem signals stable, no resp until accept.
REQ-041 SHALL cover invalidate: write 0x040, invalidate 0x040 -> WB addr 0x000001, resp_hit=1; following read misses.
REQ-042 SHALL cover saturation: STAT_W=2, 4 reads -> stat_reads stays 3.
